// File: rtl/alu_share_if.sv
// alu_share_if: request/response bundle between two ALU requesters, a result consumer and alu_share_arbiter
interface alu_share_if #(parameter int TAG_W = 2);
  logic             req0_valid;
  logic             req0_ready;
  logic [4:0]       req0_opcode;
  logic [2:0]       req0_func3;
  logic             req0_func7;
  logic [31:0]      req0_op1;
  logic [31:0]      req0_op2;
  logic [TAG_W-1:0] req0_tag;
  logic             req1_valid;
  logic             req1_ready;
  logic [4:0]       req1_opcode;
  logic [2:0]       req1_func3;
  logic             req1_func7;
  logic [31:0]      req1_op1;
  logic [31:0]      req1_op2;
  logic [TAG_W-1:0] req1_tag;
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [TAG_W-1:0] rsp_tag;
  logic [31:0]      rsp_data;
  logic             rsp_err;
  modport master (
    output req0_valid, req0_opcode, req0_func3, req0_func7, req0_op1, req0_op2, req0_tag,
    output req1_valid, req1_opcode, req1_func3, req1_func7, req1_op1, req1_op2, req1_tag,
    output rsp_ready,
    input  req0_ready, req1_ready, rsp_valid, rsp_id, rsp_tag, rsp_data, rsp_err
  );
  modport slave (
    input  req0_valid, req0_opcode, req0_func3, req0_func7, req0_op1, req0_op2, req0_tag,
    input  req1_valid, req1_opcode, req1_func3, req1_func7, req1_op1, req1_op2, req1_tag,
    input  rsp_ready,
    output req0_ready, req1_ready, rsp_valid, rsp_id, rsp_tag, rsp_data, rsp_err
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: one RV32I ALU shared by two requesters, fixed priority with starvation guard, registered response
module alu_share_arbiter #(
  parameter int TAG_W      = 2,
  parameter int STARVE_MAX = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_share_if.slave       bus,
  output logic [CNT_W-1:0] contention_cnt
);
  localparam int SW = $clog2(STARVE_MAX + 1);
  logic             rsp_valid_q, rsp_valid_d, rsp_id_q, rsp_id_d, rsp_err_q, rsp_err_d;
  logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;
  logic [31:0]      rsp_data_q, rsp_data_d;
  logic [SW-1:0]    starve_q, starve_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             can_issue, g0, g1, issue, starved;
  logic [4:0]       opc;
  logic [2:0]       f3;
  logic             f7, illegal, br, lt_s, lt_u;
  logic [TAG_W-1:0] tag;
  logic [31:0]      op1, op2, sra, arith, alu_out;
  logic [4:0]       sh;
  assign can_issue = !rsp_valid_q || bus.rsp_ready;
  assign starved   = starve_q == SW'(STARVE_MAX);
  assign g1        = can_issue && bus.req1_valid && (!bus.req0_valid || starved);
  assign g0        = can_issue && bus.req0_valid && !g1;
  assign issue     = g0 || g1;
  assign opc = g1 ? bus.req1_opcode : bus.req0_opcode;
  assign f3  = g1 ? bus.req1_func3  : bus.req0_func3;
  assign f7  = g1 ? bus.req1_func7  : bus.req0_func7;
  assign op1 = g1 ? bus.req1_op1    : bus.req0_op1;
  assign op2 = g1 ? bus.req1_op2    : bus.req0_op2;
  assign tag = g1 ? bus.req1_tag    : bus.req0_tag;
  assign sh   = op2[4:0];
  assign sra  = $signed(op1) >>> sh;
  assign lt_s = $signed(op1) < $signed(op2);
  assign lt_u = op1 < op2;
  assign illegal = !(opc inside {5'b01100, 5'b00000, 5'b00100, 5'b11001, 5'b01101,
                                 5'b00101, 5'b11011, 5'b11000, 5'b01000})
                   || (opc == 5'b11000 && f3[2:1] == 2'b01);
  always_comb begin
    arith = '0;
    case (f3)
      3'b000:  arith = (f7 && opc == 5'b01100) ? op1 - op2 : op1 + op2;
      3'b001:  arith = op1 << sh;
      3'b010:  arith = {31'b0, lt_s};
      3'b011:  arith = {31'b0, lt_u};
      3'b100:  arith = op1 ^ op2;
      3'b101:  arith = f7 ? sra : op1 >> sh;
      3'b110:  arith = op1 | op2;
      default: arith = op1 & op2;
    endcase
  end
  always_comb begin
    br = 1'b0;
    case (f3)
      3'b000:  br = op1 == op2;
      3'b001:  br = op1 != op2;
      3'b100:  br = lt_s;
      3'b101:  br = !lt_s;
      3'b110:  br = lt_u;
      3'b111:  br = !lt_u;
      default: br = 1'b0;
    endcase
  end
  always_comb begin
    alu_out = '0;
    case (opc)
      5'b01100, 5'b00100:          alu_out = arith;
      5'b11000:                    alu_out = {31'b0, br};
      5'b11001, 5'b11011:          alu_out = op1 + 32'd4;
      5'b01101:                    alu_out = op2;
      5'b00000, 5'b01000, 5'b00101: alu_out = op1 + op2;
      default:                     alu_out = '0;
    endcase
  end
  always_comb begin
    rsp_valid_d = issue ? 1'b1 : rsp_valid_q && !bus.rsp_ready;
    rsp_id_d    = issue ? g1 : rsp_id_q;
    rsp_tag_d   = issue ? tag : rsp_tag_q;
    rsp_err_d   = issue ? illegal : rsp_err_q;
    rsp_data_d  = issue ? (illegal ? 32'h0 : alu_out) : rsp_data_q;
    starve_d    = !can_issue ? starve_q :
                  (!bus.req1_valid || g1) ? '0 :
                  starved ? starve_q : starve_q + 1'b1;
    cnt_d       = (can_issue && bus.req0_valid && bus.req1_valid && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_tag_q   <= '0;
      rsp_data_q  <= '0;
      starve_q    <= '0;
      cnt_q       <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_err_q   <= rsp_err_d;
      rsp_tag_q   <= rsp_tag_d;
      rsp_data_q  <= rsp_data_d;
      starve_q    <= starve_d;
      cnt_q       <= cnt_d;
    end
  end
  assign bus.req0_ready  = g0;
  assign bus.req1_ready  = g1;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_id      = rsp_id_q;
  assign bus.rsp_tag     = rsp_tag_q;
  assign bus.rsp_data    = rsp_data_q;
  assign bus.rsp_err     = rsp_err_q;
  assign contention_cnt  = cnt_q;
endmodule
